// File: rtl/vga_timing_scaled.sv
// vga_timing_scaled: raster timing generator that also maps the active area onto an
// integer-scaled source window.
//
// The h/v counters free-run over H_TOTAL x V_TOTAL. A rising edge on frame_sync_in is
// synchronised, and when lock_en is set it realigns both counters to (0,0). Every output is
// decoded from the counter state and then delayed by PIPE register stages, so all outputs
// stay mutually aligned.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-high reset
//   frame_sync_in     asynchronous frame-start request (rising edge)
//   lock_en           enables realignment to frame_sync_in
//   hs, vs            syncs at the configured polarity
//   de, x, y          active video flag and active coordinates (0 outside the active area)
//   win_en            pixel lies inside the scaled window
//   win_x, win_y      source pixel coordinates (0 outside the window)
//   win_grid          first raster row or column of a source pixel
//   line_start        one-cycle pulse at h=0
//   frame_start       one-cycle pulse at h=0, v=0
//   locked            frame alignment status
module vga_timing_scaled #(
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned SCALE   = 3,
    parameter int unsigned WIN_W   = 160,
    parameter int unsigned WIN_H   = 144,
    parameter int unsigned WIN_X0  = 80,
    parameter int unsigned WIN_Y0  = 24,
    parameter int unsigned PIPE    = 2,
    parameter int unsigned CW      = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_sync_in,
    input  logic          lock_en,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          win_en,
    output logic [7:0]    win_x,
    output logic [7:0]    win_y,
    output logic          win_grid,
    output logic          line_start,
    output logic          frame_start,
    output logic          locked
);

    localparam int unsigned H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FRONT);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACT + V_FRONT);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACT + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] WX_BEG  = CW'(WIN_X0);
    localparam logic [CW-1:0] WX_END  = CW'(WIN_X0 + WIN_W * SCALE);
    localparam logic [CW-1:0] WY_BEG  = CW'(WIN_Y0);
    localparam logic [CW-1:0] WY_END  = CW'(WIN_Y0 + WIN_H * SCALE);
    localparam logic [2:0]    SUB_LAST = 3'(SCALE - 1);

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          win_en;
        logic [7:0]    win_x;
        logic [7:0]    win_y;
        logic          win_grid;
        logic          line_start;
        logic          frame_start;
        logic          locked;
    } out_t;

    localparam out_t OUT_RST = '{hs: ~HS_POL, vs: ~VS_POL, default: '0};

    // ---------------------------------------------------------------------------------------
    // Frame sync: 2-FF synchroniser, third stage for edge detection, registered edge pulse.
    // ---------------------------------------------------------------------------------------
    logic [2:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], frame_sync_in};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    // ---------------------------------------------------------------------------------------
    // Raster counters and lock tracking
    // ---------------------------------------------------------------------------------------
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [1:0]    miss_q, miss_d;
    logic          locked_q, locked_d;
    logic          h_wrap, v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = h_wrap && (v_q == V_LAST);

    always_comb begin
        h_d      = h_wrap ? '0 : h_q + 1'b1;
        v_d      = v_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end
        if (!lock_en) begin
            miss_d   = '0;
            locked_d = 1'b0;
        end else if (edge_q) begin
            // Realignment wins over a coincident natural wrap: one jump to (0,0), no double pulse.
            h_d      = '0;
            v_d      = '0;
            miss_d   = '0;
            locked_d = (v_q == V_LAST) || (v_q == '0);
        end else if (v_wrap) begin
            // A second frame without a sync edge drops the lock.
            if (miss_q != 2'd0) begin
                locked_d = 1'b0;
            end
            miss_d = (miss_q == 2'd2) ? 2'd2 : miss_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Window divider counters. They track the counter state exactly; they are restarted at the
    // window's left/top edge, so whatever they hold elsewhere is never used.
    // ---------------------------------------------------------------------------------------
    logic [2:0] xs_q, xs_d, ys_q, ys_d;
    logic [7:0] xw_q, xw_d, yw_q, yw_d;

    always_comb begin
        xs_d = xs_q;
        xw_d = xw_q;
        ys_d = ys_q;
        yw_d = yw_q;
        if (h_d == WX_BEG) begin
            xs_d = '0;
            xw_d = '0;
        end else if (xs_q == SUB_LAST) begin
            xs_d = '0;
            xw_d = xw_q + 8'd1;
        end else begin
            xs_d = xs_q + 3'd1;
        end
        // Vertical counters advance once per line start, including a forced one.
        if (h_d == '0) begin
            if (v_d == WY_BEG) begin
                ys_d = '0;
                yw_d = '0;
            end else if (ys_q == SUB_LAST) begin
                ys_d = '0;
                yw_d = yw_q + 8'd1;
            end else begin
                ys_d = ys_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs_q <= '0;
            xw_q <= '0;
            ys_q <= '0;
            yw_q <= '0;
        end else begin
            xs_q <= xs_d;
            xw_q <= xw_d;
            ys_q <= ys_d;
            yw_q <= yw_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Output decode from the counter state
    // ---------------------------------------------------------------------------------------
    out_t out_c;
    logic de_c, vact_c, win_c;

    always_comb begin
        vact_c = (v_q < V_ACT_C);
        de_c   = (h_q < H_ACT_C) && vact_c;
        win_c  = de_c && (h_q >= WX_BEG) && (h_q < WX_END) && (v_q >= WY_BEG) && (v_q < WY_END);

        out_c             = OUT_RST;
        out_c.hs          = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
        out_c.vs          = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
        out_c.de          = de_c;
        out_c.x           = de_c ? h_q : '0;
        // y stays valid across the horizontal blanking of active lines.
        out_c.y           = vact_c ? v_q : '0;
        out_c.win_en      = win_c;
        out_c.win_x       = win_c ? xw_q : '0;
        out_c.win_y       = win_c ? yw_q : '0;
        out_c.win_grid    = win_c && ((xs_q == '0) || (ys_q == '0));
        out_c.line_start  = (h_q == '0);
        out_c.frame_start = (h_q == '0) && (v_q == '0);
        out_c.locked      = locked_q;
    end

    // ---------------------------------------------------------------------------------------
    // Output pipeline
    // ---------------------------------------------------------------------------------------
    out_t pipe_q [PIPE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_q[i] <= OUT_RST;
            end
        end else begin
            pipe_q[0] <= out_c;
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign hs          = pipe_q[PIPE-1].hs;
    assign vs          = pipe_q[PIPE-1].vs;
    assign de          = pipe_q[PIPE-1].de;
    assign x           = pipe_q[PIPE-1].x;
    assign y           = pipe_q[PIPE-1].y;
    assign win_en      = pipe_q[PIPE-1].win_en;
    assign win_x       = pipe_q[PIPE-1].win_x;
    assign win_y       = pipe_q[PIPE-1].win_y;
    assign win_grid    = pipe_q[PIPE-1].win_grid;
    assign line_start  = pipe_q[PIPE-1].line_start;
    assign frame_start = pipe_q[PIPE-1].frame_start;
    assign locked      = pipe_q[PIPE-1].locked;

endmodule

// File: tb/tb_vga_timing_scaled.sv
// Self-checking bench for vga_timing_scaled on a reduced raster so that several frames fit in
// a short run. A frame-position model (linear pixel index, arithmetic decode of h/v and window
// coordinates) predicts every output each cycle; directed checks cover lock acquire/loss,
// sync latency and mid-frame reset.
module tb_vga_timing_scaled;

    localparam int H_ACT   = 40;
    localparam int H_FRONT = 4;
    localparam int H_SYNC  = 6;
    localparam int H_BACK  = 6;
    localparam int V_ACT   = 30;
    localparam int V_FRONT = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 3;
    localparam bit HS_POL  = 1'b1;
    localparam bit VS_POL  = 1'b0;
    localparam int SCALE   = 3;
    localparam int WIN_W   = 8;
    localparam int WIN_H   = 6;
    localparam int WIN_X0  = 16;
    localparam int WIN_Y0  = 12;
    localparam int PIPE    = 2;
    localparam int CW      = 8;

    localparam int HT    = H_ACT + H_FRONT + H_SYNC + H_BACK;
    localparam int VT    = V_ACT + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_sync_in = 1'b0;
    logic          lock_en = 1'b0;
    logic          hs, vs, de, win_en, win_grid, line_start, frame_start, locked;
    logic [CW-1:0] x, y;
    logic [7:0]    win_x, win_y;

    vga_timing_scaled #(
        .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .SCALE(SCALE), .WIN_W(WIN_W), .WIN_H(WIN_H),
        .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .PIPE(PIPE), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .frame_sync_in(frame_sync_in), .lock_en(lock_en),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .win_en(win_en), .win_x(win_x),
        .win_y(win_y), .win_grid(win_grid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          win_en;
        logic [7:0]    win_x;
        logic [7:0]    win_y;
        logic          win_grid;
        logic          line_start;
        logic          frame_start;
        logic          locked;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t rst_exp();
        exp_t e;
        e    = '0;
        e.hs = !HS_POL;
        e.vs = !VS_POL;
        return e;
    endfunction

    // Expected outputs for linear frame position p.
    function automatic exp_t expect_at(int p, bit lk);
        exp_t e;
        int h, v, dx, dy;
        h  = p % HT;
        v  = p / HT;
        dx = h - WIN_X0;
        dy = v - WIN_Y0;
        e  = '0;
        e.hs = (h >= H_ACT + H_FRONT && h < H_ACT + H_FRONT + H_SYNC) ? HS_POL : !HS_POL;
        e.vs = (v >= V_ACT + V_FRONT && v < V_ACT + V_FRONT + V_SYNC) ? VS_POL : !VS_POL;
        e.de = (h < H_ACT) && (v < V_ACT);
        e.x  = e.de ? CW'(h) : '0;
        e.y  = (v < V_ACT) ? CW'(v) : '0;
        e.win_en = e.de && dx >= 0 && dx < WIN_W * SCALE && dy >= 0 && dy < WIN_H * SCALE;
        if (e.win_en) begin
            e.win_x    = 8'(dx / SCALE);
            e.win_y    = 8'(dy / SCALE);
            e.win_grid = (dx % SCALE == 0) || (dy % SCALE == 0);
        end
        e.line_start  = (h == 0);
        e.frame_start = (p == 0);
        e.locked      = lk;
        return e;
    endfunction

    // Reference model state
    int       m_pos = 0;
    bit       m_locked = 1'b0;
    int       m_miss = 0;
    bit [5:0] fs_hist = '0;
    exp_t     m_pipe [PIPE];
    exp_t     cur;

    initial begin
        for (int i = 0; i < PIPE; i++) m_pipe[i] = rst_exp();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pos    = 0;
                m_locked = 1'b0;
                m_miss   = 0;
                fs_hist  = '0;
                for (int i = 0; i < PIPE; i++) m_pipe[i] = rst_exp();
            end else begin
                bit sync_edge;
                fs_hist = {fs_hist[4:0], frame_sync_in};
                // A rise sampled three edges ago takes effect at this edge.
                sync_edge = fs_hist[3] && !fs_hist[4];
                for (int i = PIPE - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = expect_at(m_pos, m_locked);
                if (!lock_en) begin
                    m_locked = 1'b0;
                    m_miss   = 0;
                    m_pos    = (m_pos + 1) % FRAME;
                end else if (sync_edge) begin
                    m_locked = (m_pos / HT == VT - 1) || (m_pos / HT == 0);
                    m_miss   = 0;
                    m_pos    = 0;
                end else begin
                    m_pos = (m_pos + 1) % FRAME;
                    if (m_pos == 0) begin
                        m_miss++;
                        if (m_miss >= 2) m_locked = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cur = m_pipe[PIPE-1];
                check_val("ctl", {hs, vs, de, line_start, frame_start, locked},
                          {cur.hs, cur.vs, cur.de, cur.line_start, cur.frame_start, cur.locked});
                check_val("x", x, cur.x);
                check_val("y", y, cur.y);
                check_val("win", {win_en, win_grid}, {cur.win_en, cur.win_grid});
                check_val("win_x", win_x, cur.win_x);
                check_val("win_y", win_y, cur.win_y);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int width);
        frame_sync_in = 1'b1;
        step(width);
        frame_sync_in = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        step(3);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Free run with lock disabled; sync pulses must be ignored.
        lock_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(50, 600));
            pulse($urandom_range(1, 4));
        end
        step(FRAME);

        // Lock acquire: first pulse realigns, second one a frame later locks.
        lock_en = 1'b1;
        step($urandom_range(100, 1500));
        pulse(2);
        step(PIPE + 2);
        check_val("fs_latency", frame_start, 1);
        step(FRAME - PIPE - 4);
        pulse(2);
        step(PIPE + 2);
        check_val("acq_fs", frame_start, 1);
        check_val("acq_locked", locked, 1);
        step(FRAME - PIPE - 4);
        pulse(2);
        step(PIPE + 2);
        check_val("hold_locked", locked, 1);

        // Lock loss: stop pulses; lock survives one missed frame, drops on the second.
        step(2 * FRAME - 1);
        check_val("loss_pre", locked, 1);
        step(1);
        check_val("loss_post", locked, 0);

        // Random sync pulses with lock_en toggling.
        for (int i = 0; i < 10; i++) begin
            lock_en = 1'($urandom_range(0, 1));
            step($urandom_range(20, 2500));
            pulse($urandom_range(1, 3));
        end
        step(200);

        // Mid-frame asynchronous reset.
        step($urandom_range(300, 1500));
        reset = 1'b1;
        #1;
        check_val("rst_de", de, 0);
        check_val("rst_hs", hs, !HS_POL);
        check_val("rst_vs", vs, !VS_POL);
        check_val("rst_lock", {locked, frame_start, win_en}, 0);
        step(3);
        reset = 1'b0;
        step(PIPE - 1);
        check_val("restart_early", frame_start, 0);
        step(1);
        check_val("restart_fs", frame_start, 1);

        lock_en = 1'b0;
        step(FRAME + 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
